fakeram_1rw_mask_init: RTL and testbench

// - Parametrised single-port (1RW) fakeram: behavioural SRAM stand-in for macro placeholders in flow tests.
// - Adds honoured chip enable, per-bit write mask and selectable read latency (1 or 2).
// - Adds a post-reset init sequencer that clears the array, plus a read-valid strobe.
// - Sits where a hard SRAM macro would; synthesizable for small BITS/WORD_DEPTH test configurations.

---
 rtl/fakeram_pkg.sv | 8 +
 rtl/fakeram_1rw_mask_init_if.sv | 26 ++
 rtl/fakeram_init_seq.sv | 53 +++++
 rtl/fakeram_1rw_mask_init.sv | 103 ++++++++++
 tb/tb_fakeram_1rw_mask_init.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/fakeram_pkg.sv
// Shared types and limits for the 1RW fakeram with mask and init sequencer.
package fakeram_pkg;

    typedef enum logic {S_INIT, S_IDLE} fakeram_init_state_e;

    localparam int RD_LATENCY_MAX = 2;

endpackage

// File: rtl/fakeram_1rw_mask_init_if.sv
// User access port of the fakeram: request fields in, registered read data and status out.
interface fakeram_1rw_mask_init_if #(
    parameter int unsigned BITS       = 16,
    parameter int unsigned ADDR_WIDTH = 5
) ();

    logic                  ce_in;
    logic                  we_in;
    logic [ADDR_WIDTH-1:0] addr_in;
    logic [BITS-1:0]       wd_in;
    logic [BITS-1:0]       wmask_in;
    logic [BITS-1:0]       rd_out;
    logic                  rd_valid_out;
    logic                  busy_out;

    modport master (
        output ce_in, we_in, addr_in, wd_in, wmask_in,
        input  rd_out, rd_valid_out, busy_out
    );

    modport slave (
        input  ce_in, we_in, addr_in, wd_in, wmask_in,
        output rd_out, rd_valid_out, busy_out
    );

endinterface

// File: rtl/fakeram_init_seq.sv
// Post-reset sequencer: walks every word once, then parks in S_IDLE until the next reset.
module fakeram_init_seq
    import fakeram_pkg::*;
#(
    parameter int unsigned WORD_DEPTH = 2,
    parameter int unsigned CNT_WIDTH  = 1
) (
    input  logic                 clk,
    input  logic                 rst_in,
    output logic                 busy_o,
    output logic                 init_we_o,
    output logic [CNT_WIDTH-1:0] init_addr_o
);

    localparam logic [CNT_WIDTH-1:0] LastCnt = CNT_WIDTH'(WORD_DEPTH - 1);

    fakeram_init_state_e state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_o    = 1'b0;
        init_we_o = 1'b0;
        unique case (state_q)
            S_INIT: begin
                busy_o    = 1'b1;
                init_we_o = 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
            end
            default: state_d = S_INIT;
        endcase
    end

    assign init_addr_o = cnt_q;

endmodule

// File: rtl/fakeram_1rw_mask_init.sv
// Behavioural 1RW SRAM stand-in: chip enable, bit-masked writes, read-first,
// 1- or 2-cycle read latency and a clearing sequencer after every reset.
module fakeram_1rw_mask_init
    import fakeram_pkg::*;
#(
    parameter int unsigned     BITS       = 16,
    parameter int unsigned     WORD_DEPTH = 2,
    parameter int unsigned     ADDR_WIDTH = 5,
    parameter int unsigned     RD_LATENCY = 1,
    parameter logic [BITS-1:0] INIT_VALUE = '0
) (
    input logic                    clk,
    input logic                    rst_in,
    fakeram_1rw_mask_init_if.slave ram_io
);

    localparam int unsigned IdxW = (WORD_DEPTH > 1) ? $clog2(WORD_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DepthL = WORD_DEPTH[ADDR_WIDTH:0];

    if (int'(RD_LATENCY) < 1 || int'(RD_LATENCY) > RD_LATENCY_MAX) begin : g_bad_latency
        $error("fakeram_1rw_mask_init: RD_LATENCY must be 1 or 2");
    end
    if ((64'(1) << ADDR_WIDTH) < 64'(WORD_DEPTH)) begin : g_bad_addr_width
        $error("fakeram_1rw_mask_init: ADDR_WIDTH too small for WORD_DEPTH");
    end

    logic [BITS-1:0] mem_q [WORD_DEPTH];
    logic            busy, init_we;
    logic [IdxW-1:0] init_addr;
    logic [IdxW-1:0] user_idx;
    logic            accept, in_range;
    logic [BITS-1:0] rd_word;
    logic [BITS-1:0] s1_data_q, s1_data_d;
    logic            s1_valid_q;

    fakeram_init_seq #(
        .WORD_DEPTH(WORD_DEPTH),
        .CNT_WIDTH (IdxW)
    ) u_init_seq (
        .clk        (clk),
        .rst_in     (rst_in),
        .busy_o     (busy),
        .init_we_o  (init_we),
        .init_addr_o(init_addr)
    );

    assign accept   = ram_io.ce_in && !busy;
    assign in_range = {1'b0, ram_io.addr_in} < DepthL;
    assign user_idx = ram_io.addr_in[IdxW-1:0];
    // Out-of-range reads return zero so no X leaves the macro.
    assign rd_word  = in_range ? mem_q[user_idx] : '0;

    // The sequencer owns the write port while busy; user accesses are not accepted then.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem_q[init_addr] <= INIT_VALUE;
        end else if (accept && ram_io.we_in && in_range) begin
            mem_q[user_idx] <= (mem_q[user_idx] & ~ram_io.wmask_in)
                             | (ram_io.wd_in & ram_io.wmask_in);
        end
    end

    always_comb begin
        s1_data_d = s1_data_q;
        if (accept) begin
            s1_data_d = rd_word;
        end
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_data_q  <= s1_data_d;
            s1_valid_q <= accept;
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic [BITS-1:0] s2_data_q;
        logic            s2_valid_q;

        always_ff @(posedge clk or posedge rst_in) begin
            if (rst_in) begin
                s2_data_q  <= '0;
                s2_valid_q <= 1'b0;
            end else begin
                s2_data_q  <= s1_data_q;
                s2_valid_q <= s1_valid_q;
            end
        end

        assign ram_io.rd_out       = s2_data_q;
        assign ram_io.rd_valid_out = s2_valid_q;
    end else begin : g_lat1
        assign ram_io.rd_out       = s1_data_q;
        assign ram_io.rd_valid_out = s1_valid_q;
    end

    assign ram_io.busy_out = busy;

endmodule

// File: tb/tb_fakeram_1rw_mask_init.sv
// Three fakeram configurations on one clock, checked every cycle against an array/pipeline model.
module tb_fakeram_1rw_mask_init;

    localparam int WDP [3] = '{2, 4, 2};
    localparam int LATP [3] = '{1, 1, 2};
    localparam logic [15:0] INITV [3] = '{16'h0000, 16'hC3C3, 16'h0000};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst  [3];
    logic        ce   [3];
    logic        we   [3];
    logic [4:0]  addr [3];
    logic [15:0] wd   [3];
    logic [15:0] wm   [3];
    logic [15:0] o_rd [3];
    logic        o_v  [3];
    logic        o_b  [3];

    logic [15:0] m_mem [3][8];
    int          m_cnt [3];
    logic        m_s1v [3];
    logic [15:0] m_s1d [3];
    logic        m_ov  [3];
    logic [15:0] m_od  [3];

    int total = 0;
    int bad   = 0;

    fakeram_1rw_mask_init_if #(.BITS(16), .ADDR_WIDTH(5)) if_a ();
    fakeram_1rw_mask_init_if #(.BITS(16), .ADDR_WIDTH(3)) if_b ();
    fakeram_1rw_mask_init_if #(.BITS(16), .ADDR_WIDTH(5)) if_c ();

    fakeram_1rw_mask_init #(
        .BITS(16), .WORD_DEPTH(2), .ADDR_WIDTH(5), .RD_LATENCY(1), .INIT_VALUE(16'h0000)
    ) dut_a (.clk(clk), .rst_in(rst[0]), .ram_io(if_a));

    fakeram_1rw_mask_init #(
        .BITS(16), .WORD_DEPTH(4), .ADDR_WIDTH(3), .RD_LATENCY(1), .INIT_VALUE(16'hC3C3)
    ) dut_b (.clk(clk), .rst_in(rst[1]), .ram_io(if_b));

    fakeram_1rw_mask_init #(
        .BITS(16), .WORD_DEPTH(2), .ADDR_WIDTH(5), .RD_LATENCY(2), .INIT_VALUE(16'h0000)
    ) dut_c (.clk(clk), .rst_in(rst[2]), .ram_io(if_c));

    assign if_a.ce_in = ce[0];  assign if_a.we_in = we[0];  assign if_a.addr_in = addr[0];
    assign if_a.wd_in = wd[0];  assign if_a.wmask_in = wm[0];
    assign if_b.ce_in = ce[1];  assign if_b.we_in = we[1];  assign if_b.addr_in = addr[1][2:0];
    assign if_b.wd_in = wd[1];  assign if_b.wmask_in = wm[1];
    assign if_c.ce_in = ce[2];  assign if_c.we_in = we[2];  assign if_c.addr_in = addr[2];
    assign if_c.wd_in = wd[2];  assign if_c.wmask_in = wm[2];
    assign o_rd[0] = if_a.rd_out; assign o_v[0] = if_a.rd_valid_out; assign o_b[0] = if_a.busy_out;
    assign o_rd[1] = if_b.rd_out; assign o_v[1] = if_b.rd_valid_out; assign o_b[1] = if_b.busy_out;
    assign o_rd[2] = if_c.rd_out; assign o_v[2] = if_c.rd_valid_out; assign o_b[2] = if_c.busy_out;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int k);
        m_cnt[k] = 0;
        m_s1v[k] = 1'b0;
        m_s1d[k] = 16'h0;
        m_ov[k]  = 1'b0;
        m_od[k]  = 16'h0;
    endtask

    task automatic set_rst(input int k, input logic v);
        rst[k] = v;
        if (v) begin
            #1;
            model_reset(k);
        end
    endtask

    task automatic drv(input int k, input logic c, input logic w, input logic [4:0] a,
                       input logic [15:0] d, input logic [15:0] m);
        ce[k] = c; we[k] = w; addr[k] = a; wd[k] = d; wm[k] = m;
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("busy%0d", k), 32'(o_b[k]), 32'(m_cnt[k] < WDP[k]));
            chk($sformatf("valid%0d", k), 32'(o_v[k]), 32'(m_ov[k]));
            chk($sformatf("rd%0d", k), 32'(o_rd[k]), 32'(m_od[k]));
        end
    endtask

    // One clock: model follows the edge, outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            logic        acc;
            logic [15:0] rdat;
            if (rst[k]) begin
                model_reset(k);
            end else begin
                acc  = ce[k] && (m_cnt[k] >= WDP[k]);
                rdat = (int'(addr[k]) < WDP[k]) ? m_mem[k][addr[k][2:0]] : 16'h0;
                if (m_cnt[k] < WDP[k]) begin
                    m_mem[k][m_cnt[k]] = INITV[k];
                    m_cnt[k]++;
                end else if (acc && we[k] && int'(addr[k]) < WDP[k]) begin
                    m_mem[k][addr[k][2:0]] = (rdat & ~wm[k]) | (wd[k] & wm[k]);
                end
                if (LATP[k] == 2) begin
                    m_ov[k] = m_s1v[k];
                    m_od[k] = m_s1d[k];
                end
                m_s1v[k] = acc;
                if (acc) m_s1d[k] = rdat;
                if (LATP[k] == 1) begin
                    m_ov[k] = m_s1v[k];
                    m_od[k] = m_s1d[k];
                end
            end
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int n;
        for (int k = 0; k < 3; k++) begin
            drv(k, 1'b0, 1'b0, 5'd0, 16'h0, 16'h0);
            for (int j = 0; j < 8; j++) m_mem[k][j] = 16'h0;
            rst[k] = 1'b1;
            model_reset(k);
        end
        @(negedge clk);
        step();
        step();
        chk("reset_rd_a", 32'(o_rd[0]), 32'h0);
        chk("reset_busy_a", 32'(o_b[0]), 32'h1);

        // Init length on dut_a: busy for exactly WORD_DEPTH cycles.
        set_rst(0, 1'b0);
        n = 0;
        for (int i = 0; i < 8 && o_b[0]; i++) begin
            n++;
            step();
        end
        chk("a_busy_cycles", 32'(n), 32'd2);

        // dut_b: reset hits in the second init cycle, then a full 4-cycle init follows.
        set_rst(1, 1'b0);
        set_rst(2, 1'b0);
        step();
        set_rst(1, 1'b1);
        step();
        set_rst(1, 1'b0);
        n = 0;
        for (int i = 0; i < 10 && o_b[1]; i++) begin
            n++;
            drv(1, 1'b1, 1'b1, 5'($urandom_range(0, 3)), 16'($urandom), 16'hFFFF);
            step();
        end
        chk("b_busy_cycles", 32'(n), 32'd4);
        drv(1, 1'b1, 1'b0, 5'd3, 16'h0, 16'h0);
        step();
        chk("b_init_word3", 32'(o_rd[1]), 32'hC3C3);
        drv(1, 1'b0, 1'b0, 5'd0, 16'h0, 16'h0);

        // dut_a directed sequence.
        drv(0, 1'b1, 1'b0, 5'd0, 16'h0, 16'h0);  step();
        chk("a_rd0", 32'(o_rd[0]), 32'h0000);   chk("a_v0", 32'(o_v[0]), 32'h1);
        drv(0, 1'b1, 1'b0, 5'd1, 16'h0, 16'h0);  step();
        chk("a_rd1", 32'(o_rd[0]), 32'h0000);   chk("a_v1", 32'(o_v[0]), 32'h1);
        drv(0, 1'b1, 1'b1, 5'd1, 16'hA5A5, 16'hFFFF);  step();
        drv(0, 1'b1, 1'b0, 5'd1, 16'h0, 16'h0);         step();
        chk("a_raw_a5a5", 32'(o_rd[0]), 32'hA5A5);
        drv(0, 1'b1, 1'b1, 5'd0, 16'h1234, 16'hFFFF);  step();
        drv(0, 1'b1, 1'b1, 5'd0, 16'hFFFF, 16'h00F0);  step();
        chk("a_write_old", 32'(o_rd[0]), 32'h1234);
        drv(0, 1'b1, 1'b0, 5'd0, 16'h0, 16'h0);         step();
        chk("a_masked", 32'(o_rd[0]), 32'h12F4);
        drv(0, 1'b0, 1'b1, 5'd0, 16'h0000, 16'hFFFF);  step();
        chk("a_ce0_valid", 32'(o_v[0]), 32'h0);  chk("a_ce0_hold", 32'(o_rd[0]), 32'h12F4);
        drv(0, 1'b1, 1'b0, 5'd0, 16'h0, 16'h0);         step();
        chk("a_ce0_unch", 32'(o_rd[0]), 32'h12F4);
        drv(0, 1'b0, 1'b0, 5'd0, 16'h0, 16'h0);

        // dut_c: two-cycle latency, back-to-back reads.
        drv(2, 1'b1, 1'b1, 5'd0, 16'h1111, 16'hFFFF);  step();
        drv(2, 1'b1, 1'b1, 5'd1, 16'h2222, 16'hFFFF);  step();
        drv(2, 1'b0, 1'b0, 5'd0, 16'h0, 16'h0);         step();  step();
        drv(2, 1'b1, 1'b0, 5'd0, 16'h0, 16'h0);  step();
        chk("c_lat_v0", 32'(o_v[2]), 32'h0);
        drv(2, 1'b1, 1'b0, 5'd1, 16'h0, 16'h0);  step();
        chk("c_r0", 32'(o_rd[2]), 32'h1111);    chk("c_r0_v", 32'(o_v[2]), 32'h1);
        drv(2, 1'b1, 1'b0, 5'd0, 16'h0, 16'h0);  step();
        chk("c_r1", 32'(o_rd[2]), 32'h2222);    chk("c_r1_v", 32'(o_v[2]), 32'h1);
        drv(2, 1'b1, 1'b0, 5'd5, 16'h0, 16'h0);  step();
        chk("c_r2", 32'(o_rd[2]), 32'h1111);    chk("c_r2_v", 32'(o_v[2]), 32'h1);
        drv(2, 1'b0, 1'b0, 5'd0, 16'h0, 16'h0);  step();
        chk("c_oor", 32'(o_rd[2]), 32'h0000);   chk("c_oor_v", 32'(o_v[2]), 32'h1);
        step();
        chk("c_tail_v", 32'(o_v[2]), 32'h0);

        // Random traffic on all three, with a reset dropped into dut_b midway.
        for (int i = 0; i < 300; i++) begin
            if (i == 150) set_rst(1, 1'b1);
            if (i == 152) set_rst(1, 1'b0);
            for (int k = 0; k < 3; k++) begin
                logic [15:0] m;
                case ($urandom_range(0, 2))
                    0:       m = 16'h0000;
                    1:       m = 16'hFFFF;
                    default: m = 16'($urandom);
                endcase
                drv(k, $urandom_range(0, 3) != 0, 1'($urandom), 5'($urandom_range(0, 7)),
                    16'($urandom), m);
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
